// File: rtl/digit_serial_adder.sv
// digit_serial_adder
// Multi-cycle adder/subtractor. Each operand is consumed DIGIT bits per clock
// through a registered carry, so a WIDTH-bit operation takes WIDTH/DIGIT RUN
// cycles. Operands enter on a valid/ready handshake and the result leaves on
// another one. The result is held until the consumer takes it.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Operand shift registers. B is already inverted for subtraction.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  // Partial result. Each new digit enters at the top and moves down.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             handoff;
  logic             last_digit;
  logic [DIGIT:0]   digit_sum;
  logic             msb_carry_in;

  // Handshake qualifiers. Each is only meaningful in its own state.
  assign accept     = (state == IDLE) && in_valid && in_ready;
  assign handoff    = (state == DONE) && out_valid && out_ready;
  assign last_digit = (state == RUN) && (cnt == LAST_DIGIT);

  // One digit of ripple addition. The extra top bit is the digit carry-out.
  assign digit_sum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry};

  // Insert the new digit at the top of the result.
  // When DIGIT == WIDTH the right shift clears acc, so the digit becomes the
  // whole word.
  assign acc_next = (acc >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // On the final digit, bit DIGIT-1 of the shifted operands is bit WIDTH-1 of
  // the originals. The carry into that bit equals a ^ b ^ s at that bit.
  assign msb_carry_in = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ digit_sum[DIGIT-1];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state is assigned with <= so every flop samples
    // pre-edge values; blocking = here would create order-dependent races.
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred when a branch does not assign.
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (handoff)    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Registered handshake outputs follow the state being entered.
  // in_ready therefore rises one edge after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Operand capture on accept, then one digit per RUN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the shift registers are reset as well. An aborted operation
    // must not leave a stale carry or stale operand bits behind.
    if (!reset_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b ^ {WIDTH{subtract}};
      carry <= carryin ^ subtract;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      acc   <= acc_next;
      carry <= digit_sum[DIGIT];
      cnt   <= cnt + 1'b1;
    end
  end

  // Result registers. They change only when an operation completes, so they
  // keep the last result through handoff and the following RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else if (last_digit) begin
      sum      <= acc_next;
      carryout <= digit_sum[DIGIT];
      overflow <= msb_carry_in ^ digit_sum[DIGIT];
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder with four instances:
//   k=0: WIDTH=8,  DIGIT=4
//   k=1: WIDTH=8,  DIGIT=1
//   k=2: WIDTH=32, DIGIT=4
//   k=3: WIDTH=8,  DIGIT=8
// The expected result is queued when operands are driven. It is popped and
// compared when out_valid appears.
module tb_digit_serial_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic in_valid_s  [4];
  logic in_ready_s  [4];
  logic carryin_s   [4];
  logic subtract_s  [4];
  logic out_valid_s [4];
  logic out_ready_s [4];
  logic carryout_s  [4];
  logic overflow_s  [4];

  logic [7:0]  a0, b0, s0;
  logic [7:0]  a1, b1, s1;
  logic [31:0] a2, b2, s2;
  logic [7:0]  a3, b3, s3;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a0), .b(b0), .carryin(carryin_s[0]), .subtract(subtract_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .sum(s0), .carryout(carryout_s[0]), .overflow(overflow_s[0])
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a1), .b(b1), .carryin(carryin_s[1]), .subtract(subtract_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .sum(s1), .carryout(carryout_s[1]), .overflow(overflow_s[1])
  );

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) u_w32d4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .a(a2), .b(b2), .carryin(carryin_s[2]), .subtract(subtract_s[2]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
    .sum(s2), .carryout(carryout_s[2]), .overflow(overflow_s[2])
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]),
    .a(a3), .b(b3), .carryin(carryin_s[3]), .subtract(subtract_s[3]),
    .out_valid(out_valid_s[3]), .out_ready(out_ready_s[3]),
    .sum(s3), .carryout(carryout_s[3]), .overflow(overflow_s[3])
  );

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wid(input int k);
    return (k == 2) ? 32 : 8;
  endfunction

  function automatic int ndig(input int k);
    case (k)
      0:       return 2;
      1:       return 8;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] get_sum(input int k);
    case (k)
      0:       return {24'd0, s0};
      1:       return {24'd0, s1};
      2:       return s2;
      default: return {24'd0, s3};
    endcase
  endfunction

  task automatic set_in(input int k, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input logic sub);
    case (k)
      0:       begin a0 = a[7:0]; b0 = b[7:0]; end
      1:       begin a1 = a[7:0]; b1 = b[7:0]; end
      2:       begin a2 = a;      b2 = b;      end
      default: begin a3 = a[7:0]; b3 = b[7:0]; end
    endcase
    in_valid_s[k] = v;
    carryin_s[k]  = cin;
    subtract_s[k] = sub;
  endtask

  // Reference: full-width arithmetic with a sign-rule overflow.
  function automatic res_t model(input int k, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    int          w;
    logic [31:0] m, aa, bb;
    logic [32:0] full;
    res_t        r;
    w    = wid(k);
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa   = a & m;
    bb   = (sub ? ~b : b) & m;
    full = {1'b0, aa} + {1'b0, bb} + {32'd0, cin ^ sub};
    r.sum  = full[31:0] & m;
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    return r;
  endfunction

  // One operation. Steps:
  //  - Wait for in_ready, then accept and queue the expected result.
  //  - Scramble the inputs during RUN and measure the latency.
  //  - Hold out_ready low for 'hold' cycles while a stray in_valid is driven.
  //  - Hand off and check the state after the handoff.
  task automatic do_transaction(input int k, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub, input res_t exp,
                                input int hold, input bit rand_ordy);
    int   n;
    res_t got;
    res_t e;
    n = 0;
    while (in_ready_s[k] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready_s[k] !== 1'b1) begin
      errors++;
      $display("FAIL k%0d in_ready_wait: in_ready=%b required 1", k, in_ready_s[k]);
      return;
    end
    out_ready_s[k] = 1'b0;
    set_in(k, 1'b1, a, b, cin, sub);
    exp_q.push_back(exp);
    tick();
    set_in(k, 1'b0, ~a, ~b, ~cin, ~sub);
    n = 0;
    while (out_valid_s[k] !== 1'b1 && n < 100) begin
      if (rand_ordy) out_ready_s[k] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    checks++;
    if (n != ndig(k)) begin
      errors++;
      $display("FAIL k%0d latency: got %0d edges required %0d", k, n, ndig(k));
      if (out_valid_s[k] !== 1'b1) begin
        void'(exp_q.pop_front());
        return;
      end
    end
    e   = exp_q.pop_front();
    got = '{sum: get_sum(k), cout: carryout_s[k], ovf: overflow_s[k]};
    checks++;
    if (got !== e)
      begin
        errors++;
        $display("FAIL k%0d result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                 k, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end
    checks++;
    if (in_ready_s[k] !== 1'b0) begin
      errors++;
      $display("FAIL k%0d in_ready_in_done: got %b required 0", k, in_ready_s[k]);
    end
    for (int i = 0; i < hold; i++) begin
      out_ready_s[k] = 1'b0;
      set_in(k, 1'b1, a ^ 32'h5A5A_5A5A, ~b, cin, sub);
      tick();
      got = '{sum: get_sum(k), cout: carryout_s[k], ovf: overflow_s[k]};
      checks++;
      if (out_valid_s[k] !== 1'b1 || in_ready_s[k] !== 1'b0 || got !== e) begin
        errors++;
        $display("FAIL k%0d hold_%0d: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b required 1 0 %h %b %b",
                 k, i, out_valid_s[k], in_ready_s[k], got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end
    end
    set_in(k, 1'b0, a, b, cin, sub);
    out_ready_s[k] = 1'b1;
    tick();
    out_ready_s[k] = 1'b0;
    checks++;
    if (out_valid_s[k] !== 1'b0 || in_ready_s[k] !== 1'b1) begin
      errors++;
      $display("FAIL k%0d handoff: out_valid=%b in_ready=%b required 0 1",
               k, out_valid_s[k], in_ready_s[k]);
    end
    checks++;
    if (get_sum(k) !== e.sum) begin
      errors++;
      $display("FAIL k%0d sum_after_handoff: got %h required %h", k, get_sum(k), e.sum);
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_in(k, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      out_ready_s[k] = 1'b0;
    end
    #2 reset_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({in_ready_s[k], out_valid_s[k], get_sum(k), carryout_s[k], overflow_s[k]} !== 36'd0) begin
        errors++;
        $display("FAIL k%0d reset_outputs: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required all 0",
                 k, in_ready_s[k], out_valid_s[k], get_sum(k), carryout_s[k], overflow_s[k]);
      end
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_pre_edge: in_ready=%b required 0", in_ready_s[0]);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready_s[k] !== 1'b1) begin
        errors++;
        $display("FAIL k%0d in_ready_after_reset: got %b required 1", k, in_ready_s[k]);
      end
    end
  endtask

  task automatic test_add();
    do_transaction(0, 32'h3C, 32'h55, 1'b0, 1'b0, '{sum: 32'h91, cout: 1'b0, ovf: 1'b1}, 0, 1'b0);
  endtask

  task automatic test_bit_serial();
    do_transaction(1, 32'hFF, 32'h01, 1'b1, 1'b0, '{sum: 32'h01, cout: 1'b1, ovf: 1'b0}, 0, 1'b0);
    do_transaction(1, 32'h7F, 32'h01, 1'b0, 1'b0, '{sum: 32'h80, cout: 1'b0, ovf: 1'b1}, 0, 1'b0);
  endtask

  task automatic test_subtract();
    do_transaction(0, 32'h05, 32'h07, 1'b0, 1'b1, '{sum: 32'hFE, cout: 1'b0, ovf: 1'b0}, 0, 1'b0);
    do_transaction(0, 32'h80, 32'h01, 1'b0, 1'b1, '{sum: 32'h7F, cout: 1'b1, ovf: 1'b1}, 0, 1'b0);
    do_transaction(0, 32'h09, 32'h03, 1'b1, 1'b1, '{sum: 32'h05, cout: 1'b1, ovf: 1'b0}, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_transaction(0, 32'h12, 32'h34, 1'b0, 1'b0, '{sum: 32'h46, cout: 1'b0, ovf: 1'b0}, 5, 1'b0);
    repeat (3) tick();
    checks++;
    if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_idle_after: out_valid=%b in_ready=%b required 0 1",
               out_valid_s[0], in_ready_s[0]);
    end
  endtask

  task automatic test_full_digit();
    do_transaction(3, 32'hC0, 32'h40, 1'b0, 1'b0, '{sum: 32'h00, cout: 1'b1, ovf: 1'b0}, 0, 1'b0);
    do_transaction(3, 32'h00, 32'h00, 1'b1, 1'b1, '{sum: 32'hFF, cout: 1'b0, ovf: 1'b0}, 1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    checks++;
    if (in_ready_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_start: in_ready=%b required 1", in_ready_s[0]);
    end
    set_in(0, 1'b1, 32'hFF, 32'hFF, 1'b1, 1'b0);
    tick();
    set_in(0, 1'b0, 32'h00, 32'h00, 1'b0, 1'b0);
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_s[0], in_ready_s[0], get_sum(0), carryout_s[0], overflow_s[0]} !== 36'd0) begin
      errors++;
      $display("FAIL mid_run_reset: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b required all 0",
               out_valid_s[0], in_ready_s[0], get_sum(0), carryout_s[0], overflow_s[0]);
    end
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_release_pre_edge: in_ready=%b required 0", in_ready_s[0]);
    end
    tick();
    checks++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_release: in_ready=%b out_valid=%b required 1 0", in_ready_s[0], out_valid_s[0]);
    end
    do_transaction(0, 32'h01, 32'h01, 1'b0, 1'b0, '{sum: 32'h02, cout: 1'b0, ovf: 1'b0}, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        cin, sub;
    for (int i = 0; i < 1000; i++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      do_transaction(2, a, b, cin, sub, model(2, a, b, cin, sub), $urandom_range(0, 2), 1'b1);
    end
  endtask

  task automatic test_queue_drained();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_bit_serial();
    test_subtract();
    test_backpressure();
    test_full_digit();
    test_reset_mid_run();
    test_random();
    test_queue_drained();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor: consumes WIDTH-bit operands DIGIT bits per clock through a registered carry, trading latency for area against the single-cycle full-adder cells.
- Supports add/subtract mode, carry-in, and carry-out/signed-overflow flags.
- Valid/ready handshakes on input and output; sits between an operand producer and a result consumer in the datapath.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT
DIGIT, 4, bits added per clock; 1 gives a bit-serial adder; DIGIT=WIDTH gives one RUN cycle
NDIG (localparam), WIDTH/DIGIT, number of RUN cycles per operation

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carryin  input  1  carry-in (add) / borrow-in (subtract)
subtract  input  1  0: a+b+carryin; 1: a-b-carryin
out_valid  output  1  result available
out_ready  input  1  consumer takes result
sum  output  WIDTH  result, modulo 2^WIDTH
carryout  output  1  raw carry out of bit WIDTH-1
overflow  output  1  two's-complement overflow

Behaviour:
- Reset (async assert, sync to clk on release): state IDLE; in_ready=0, out_valid=0, sum=0, carryout=0, overflow=0; internal carry, digit counter and shift registers cleared. in_ready rises on the first rising edge after reset_n deasserts.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at an edge: capture a, b^{WIDTH{subtract}} into shift registers; carry reg <= carryin^subtract; counter <= 0; in_ready <= 0; go RUN.
- Operands are sampled only on the accept edge; a/b/carryin/subtract changes afterwards have no effect.
- RUN: each edge adds the low DIGIT bits of both shift registers plus the carry reg. It shifts the DIGIT-bit result into the result register from the top, updates the carry reg with the digit carry-out, shifts the operands right by DIGIT, and increments the counter.
- On the edge with counter==NDIG-1:
  - sum <= completed result; carryout <= final carry.
  - overflow <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - out_valid <= 1; go DONE.
- Latency: out_valid rises exactly NDIG edges after the accept edge.
- DONE: out_valid held high, and sum/carryout/overflow held stable, until out_valid&&out_ready at an edge. That edge clears out_valid, sets in_ready, and moves to IDLE.
- No accept in the same cycle as result handoff, so throughput is one operation per NDIG+2 cycles minimum with out_ready tied high.
- sum/carryout/overflow keep the last result after handoff until the next completion; they are never updated mid-RUN.
- out_ready is ignored outside DONE; in_valid is ignored outside IDLE.
- Subtract semantics: result = a + ~b + ~carryin. With carryin=0 this gives a-b. carryout=1 means no borrow (a>=b+carryin, unsigned).
- Reset asserted mid-RUN or in DONE aborts the operation: the result is discarded and outputs return to reset values immediately.
- DIGIT=WIDTH: single RUN cycle, latency 1; behaviour otherwise identical.

Test Plan:
1. WIDTH=8, DIGIT=4: reset, then a=0x3C, b=0x55, carryin=0, subtract=0 accepted -> out_valid exactly 2 edges later; sum=0x91, carryout=0, overflow=1.
2. WIDTH=8, DIGIT=1: a=0xFF, b=0x01, carryin=1, add -> latency 8 edges; sum=0x01, carryout=1, overflow=0.
3. WIDTH=8, DIGIT=4, subtract=1:
   - a=0x05, b=0x07, carryin=0 -> sum=0xFE, carryout=0.
   - then a=0x80, b=0x01 -> sum=0x7F, carryout=1, overflow=1.
4. Backpressure, WIDTH=8, DIGIT=4: out_ready=0 for 5 cycles after out_valid.
   - Outputs must stay stable and in_ready must stay 0.
   - Change a/b during RUN: no effect on sum.
   - Raise out_ready: handoff, then in_ready=1 next cycle.
5. WIDTH=32, DIGIT=4: 1000 random operands/modes with out_ready random -> every result matches the a±b±carryin model (sum, carryout, overflow); latency always 8.
6. Assert reset_n low mid-RUN (after 1 digit) -> out_valid=0, sum=0 immediately; after release, in_ready=1 next edge; the next operation 0x01+0x01 gives sum=0x02 with no stale carry.
